divider_16: RTL and testbench

Sequential signed fixed-point divider for the attention datapath: the inverse operation of the 16-bit multiplier. It divides two Q2.13 operands (1 sign, 2 integer, 13 fraction bits) and returns a saturated Q2.13 quotient. It uses the same valid/busy handshake as the multiplier, so both sit side by side behind one issue controller, for example for softmax normalisation.

---
 rtl/divider_16.sv | 134 +++++++++++++
 tb/tb_divider_16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/divider_16.sv
// divider_16: sequential signed Q2.13 divider with a fixed 19-cycle latency.
// It uses restoring radix-2 division on magnitudes, and saturates the
// quotient and flags overflow and divide-by-zero on the same valid/busy
// handshake as the 16-bit multiplier.
module divider_16 (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic        I_VLD,
   input  logic [15:0] I_DIVIDEND,
   input  logic [15:0] I_DIVISOR,
   output logic        O_VLD,
   output logic        O_DIV_BUSY,
   output logic [15:0] O_QUOTIENT,
   output logic        O_OVF,
   output logic        O_DIV_ZERO
);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

   state_t      state, next_state;
   logic [15:0] a_reg, b_reg;
   logic [15:0] abs_b_reg;
   logic        neg_reg, dz_reg, big_reg;
   logic [16:0] rem, shreg, quot;
   logic [4:0]  cnt;

   logic [15:0] abs_a, abs_b;
   logic        big;
   logic [17:0] trial;
   logic        ge;
   logic [16:0] rem_next;
   logic        accept;

   // Next-state logic for the IDLE -> LOAD -> DIV -> OUT sequence.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: if (I_VLD) begin
            accept     = 1'b1;
            next_state = LOAD;
         end
         LOAD: next_state = DIV;
         DIV:  if (cnt == 5'd16) next_state = OUT;
         OUT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge I_CLK) begin
      if (I_RST) state <= IDLE;
      else       state <= next_state;
   end

   // Operand magnitudes and overflow pre-check from the captured operands.
   always_comb begin
      abs_a = a_reg[15] ? 16'(-a_reg) : a_reg;
      abs_b = b_reg[15] ? 16'(-b_reg) : b_reg;
      big   = ({4'b0, abs_a} >= {abs_b, 4'b0});
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial    = {rem, shreg[16]};
      ge       = (trial >= {2'b0, abs_b_reg});
      rem_next = ge ? 17'(trial - {2'b0, abs_b_reg}) : trial[16:0];
   end

   // Datapath: operand capture, pre-check, iteration and result formatting.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         a_reg      <= '0;
         b_reg      <= '0;
         abs_b_reg  <= '0;
         neg_reg    <= 1'b0;
         dz_reg     <= 1'b0;
         big_reg    <= 1'b0;
         rem        <= '0;
         shreg      <= '0;
         quot       <= '0;
         cnt        <= '0;
         O_VLD      <= 1'b0;
         O_DIV_BUSY <= 1'b0;
         O_QUOTIENT <= '0;
         O_OVF      <= 1'b0;
         O_DIV_ZERO <= 1'b0;
      end else begin
         O_VLD      <= (state == OUT);
         O_DIV_BUSY <= (state != IDLE);
         if (accept) begin
            a_reg <= I_DIVIDEND;
            b_reg <= I_DIVISOR;
         end
         if (state == LOAD) begin
            abs_b_reg <= abs_b;
            neg_reg   <= a_reg[15] ^ b_reg[15];
            dz_reg    <= (b_reg == 16'h0000);
            big_reg   <= big;
            quot      <= '0;
            cnt       <= '0;
            // The top 12 quotient bits of (|A|<<13)/|B| are zero whenever
            // the pre-check passes, so the partial remainder starts as if
            // those 12 steps had already run: it holds |A|[15:4] and only
            // the low 17 dividend bits remain to be shifted in.
            rem       <= {5'b0, abs_a[15:4]};
            shreg     <= {abs_a[3:0], 13'b0};
         end
         if (state == DIV) begin
            rem   <= rem_next;
            quot  <= {quot[15:0], ge};
            shreg <= {shreg[15:0], 1'b0};
            cnt   <= cnt + 5'd1;
         end
         if (state == OUT) begin
            if (dz_reg) begin
               O_QUOTIENT <= a_reg[15] ? 16'h8000 : 16'h7FFF;
               O_DIV_ZERO <= 1'b1;
               O_OVF      <= 1'b0;
            end else if (big_reg || (!neg_reg && quot > 17'd32767) ||
                         (neg_reg && quot > 17'd32768)) begin
               O_QUOTIENT <= neg_reg ? 16'h8000 : 16'h7FFF;
               O_DIV_ZERO <= 1'b0;
               O_OVF      <= 1'b1;
            end else begin
               O_QUOTIENT <= neg_reg ? 16'(-quot[15:0]) : quot[15:0];
               O_DIV_ZERO <= 1'b0;
               O_OVF      <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_divider_16.sv
// tb_divider_16: directed vectors and a back-to-back random soak for divider_16.
module tb_divider_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic [15:0] dividend, divisor;
   logic        o_vld, o_busy, o_ovf, o_dz;
   logic [15:0] o_q;

   int unsigned passed = 0;
   int unsigned total  = 0;

   divider_16 dut (
      .I_CLK      (clk),
      .I_RST      (rst),
      .I_VLD      (vld),
      .I_DIVIDEND (dividend),
      .I_DIVISOR  (divisor),
      .O_VLD      (o_vld),
      .O_DIV_BUSY (o_busy),
      .O_QUOTIENT (o_q),
      .O_OVF      (o_ovf),
      .O_DIV_ZERO (o_dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference: {dz, ovf, quotient}.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
      longint num, qq;
      if (b == 16'h0000) return {1'b1, 1'b0, (a[15] ? 16'h8000 : 16'h7FFF)};
      num = longint'($signed(a)) <<< 13;
      qq  = num / longint'($signed(b));
      if (qq > 32767)  return {2'b01, 16'h7FFF};
      if (qq < -32768) return {2'b01, 16'h8000};
      return {2'b00, qq[15:0]};
   endfunction

   // Present an operation; it is accepted at the next rising edge.
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      vld      = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      vld      = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Wait for O_VLD, counting edges since accept and busy-high samples.
   task automatic wait_result(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         lat = i;
         if (o_busy) busy_cnt++;
         if (o_vld) break;
      end
   endtask

   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic eovf, input logic edz);
      int lat, bc;
      start(a, b);
      wait_result(lat, bc);
      check({tag, "_lat"}, lat, 19);
      check({tag, "_q"}, o_q, eq);
      check({tag, "_flags"}, {o_ovf, o_dz}, {eovf, edz});
   endtask

   initial begin
      int lat, bc, nvld, fails_before;
      logic [15:0] ra, rb;
      logic [17:0] exp;

      rst = 1'b1; vld = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", {o_vld, o_busy, o_q, o_ovf, o_dz}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic: latency, busy width, pulse width, held result.
      start(16'h2000, 16'h4000);
      check("basic_busy_k", o_busy, 0);
      wait_result(lat, bc);
      check("basic_lat", lat, 19);
      check("basic_busy_cnt", bc, 19);
      check("basic_q", o_q, 16'h1000);
      check("basic_flags", {o_ovf, o_dz}, 2'b00);
      @(posedge clk); #1;
      check("basic_vld_pulse", o_vld, 0);
      check("basic_busy_end", o_busy, 0);
      check("basic_q_hold", o_q, 16'h1000);

      directed("trunc_pos", 16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0);
      directed("trunc_neg", 16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0);
      directed("neg_exact", 16'hE000, 16'h4000, 16'hF000, 1'b0, 1'b0);
      directed("sat_big",   16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
      directed("min_exact", 16'h8000, 16'h2000, 16'h8000, 1'b0, 1'b0);
      directed("sat_pos",   16'h8000, 16'hE000, 16'h7FFF, 1'b1, 1'b0);
      directed("dz_neg",    16'hC000, 16'h0000, 16'h8000, 1'b0, 1'b1);
      directed("dz_zero",   16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
      directed("zero_num",  16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0);

      // I_VLD while busy is ignored; exactly one result.
      start(16'h2000, 16'h4000);
      repeat (5) @(posedge clk);
      #1;
      vld = 1'b1; dividend = 16'h7FFF; divisor = 16'h0000;
      @(posedge clk); #1;
      vld = 1'b0;
      wait_result(lat, bc);
      check("ignore_lat", lat, 13);
      check("ignore_q", o_q, 16'h1000);
      check("ignore_flags", {o_ovf, o_dz}, 2'b00);
      nvld = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (o_vld) nvld++;
      end
      check("ignore_single_vld", nvld, 0);

      // Reset mid-operation aborts; reset wins over a same-cycle I_VLD.
      start(16'hE000, 16'h6000);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1; vld = 1'b1; dividend = 16'h2000; divisor = 16'h4000;
      @(posedge clk); #1;
      check("rst_outs", {o_vld, o_busy, o_q, o_ovf, o_dz}, 0);
      rst = 1'b0; vld = 1'b0;
      nvld = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (o_vld || o_busy) nvld++;
      end
      check("rst_no_activity", nvld, 0);

      directed("after_rst", 16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0);

      // Back-to-back random soak; the next op is issued for edge k+20.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 2 == 1) rb = {{6{rb[15]}}, rb[9:0]};
         if (i % 5 == 4) ra = {{4{ra[15]}}, ra[11:0]};
         exp = model(ra, rb);
         fails_before = total - passed;
         start(ra, rb);
         wait_result(lat, bc);
         check("soak_lat", lat, 19);
         check("soak_result", {o_dz, o_ovf, o_q}, exp);
         if (total - passed != fails_before) break;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
